// File: rtl/magnitude_compare_tracker_if.sv
// Handshake and statistics bundle between the upstream comparator, the tracker
// and its consumer.
interface magnitude_compare_tracker_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_L;
  logic             out_E;
  logic             out_G;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [CNT_W-1:0] cnt_L;
  logic [CNT_W-1:0] cnt_E;
  logic [CNT_W-1:0] cnt_G;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_first, out_L, out_E, out_G,
           max_val, min_val, cnt_L, cnt_E, cnt_G
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_first, out_L, out_E, out_G,
           max_val, min_val, cnt_L, cnt_E, cnt_G
  );
endinterface

// File: rtl/magnitude_compare_tracker.sv
// Registers the unsigned compare of each accepted sample against the previous
// one, with backpressure, running max/min and saturating outcome counters.
module magnitude_compare_tracker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  magnitude_compare_tracker_if.slave bus
);
  typedef enum logic {EMPTY, TRACK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, max_q, max_d, min_q, min_d;
  logic [CNT_W-1:0] cnt_l_q, cnt_l_d, cnt_e_q, cnt_e_d, cnt_g_q, cnt_g_d;
  logic             out_valid_q, out_valid_d, first_q, first_d;
  logic             l_q, l_d, e_q, e_d, g_q, g_d;
  logic             in_ready, accept, xfer;

  assign in_ready = !clr && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    max_d       = max_q;
    min_d       = min_q;
    cnt_l_d     = cnt_l_q;
    cnt_e_d     = cnt_e_q;
    cnt_g_d     = cnt_g_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    l_d         = l_q;
    e_d         = e_q;
    g_d         = g_q;
    if (clr) begin
      state_d     = EMPTY;
      prev_d      = '0;
      max_d       = '0;
      min_d       = '0;
      cnt_l_d     = '0;
      cnt_e_d     = '0;
      cnt_g_d     = '0;
      out_valid_d = 1'b0;
      first_d     = 1'b0;
      l_d         = 1'b0;
      e_d         = 1'b0;
      g_d         = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      prev_d      = bus.in_data;
      state_d     = TRACK;
      if (state_q == EMPTY) begin
        first_d = 1'b1;
        l_d     = 1'b0;
        e_d     = 1'b0;
        g_d     = 1'b0;
        max_d   = bus.in_data;
        min_d   = bus.in_data;
      end else begin
        first_d = 1'b0;
        l_d     = bus.in_data <  prev_q;
        e_d     = bus.in_data == prev_q;
        g_d     = bus.in_data >  prev_q;
        // Counters stick at all-ones rather than wrapping.
        if (l_d && cnt_l_q != '1) cnt_l_d = cnt_l_q + CNT_W'(1);
        if (e_d && cnt_e_q != '1) cnt_e_d = cnt_e_q + CNT_W'(1);
        if (g_d && cnt_g_q != '1) cnt_g_d = cnt_g_q + CNT_W'(1);
        if (bus.in_data > max_q) max_d = bus.in_data;
        if (bus.in_data < min_q) min_d = bus.in_data;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      max_q       <= '0;
      min_q       <= '0;
      cnt_l_q     <= '0;
      cnt_e_q     <= '0;
      cnt_g_q     <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      l_q         <= 1'b0;
      e_q         <= 1'b0;
      g_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      max_q       <= max_d;
      min_q       <= min_d;
      cnt_l_q     <= cnt_l_d;
      cnt_e_q     <= cnt_e_d;
      cnt_g_q     <= cnt_g_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      l_q         <= l_d;
      e_q         <= e_d;
      g_q         <= g_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = first_q;
  assign bus.out_L     = l_q;
  assign bus.out_E     = e_q;
  assign bus.out_G     = g_q;
  assign bus.max_val   = max_q;
  assign bus.min_val   = min_q;
  assign bus.cnt_L     = cnt_l_q;
  assign bus.cnt_E     = cnt_e_q;
  assign bus.cnt_G     = cnt_g_q;
endmodule
